// File: rtl/int_ctrl.sv
// int_ctrl: picks the highest-priority pending interrupt, requests a trap and tracks handlers in service.
// Optional feature macro INT_NEST_EN: lets a strictly higher-priority source preempt an active handler.
module int_ctrl #(
   parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  IR,
   input  logic        ie,
   input  logic        int_ack,
   input  logic        eret,
   output logic        int_req,
   output logic [1:0]  int_id,
   output logic [31:0] int_vec,
   output logic [2:0]  in_service,
   output logic        Clr,
   output logic [2:0]  ClrInt
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state, state_next;
   logic [2:0] eligible, set_mask, retire_mask, in_service_next;
   logic [1:0] cand_idx;
   logic       cand_vld, prio_ok, qualify, retire;

   // Bits being cleared this cycle still show in IR until the next edge.
   assign eligible = IR & ~in_service & ~ClrInt;

   always_comb begin
      cand_vld = 1'b1;
      cand_idx = 2'd0;
      if (eligible[2])      cand_idx = 2'd2;
      else if (eligible[1]) cand_idx = 2'd1;
      else if (eligible[0]) cand_idx = 2'd0;
      else                  cand_vld = 1'b0;
   end

   always_comb begin
      retire_mask = 3'b000;
      if (in_service[2])      retire_mask = 3'b100;
      else if (in_service[1]) retire_mask = 3'b010;
      else if (in_service[0]) retire_mask = 3'b001;
   end

`ifdef INT_NEST_EN
   // A one-hot candidate outranks every in-service bit exactly when it is numerically larger.
   assign prio_ok = ((3'b001 << cand_idx) > in_service);
`else
   assign prio_ok = (in_service == 3'b000);
`endif

   assign qualify  = ie && cand_vld && prio_ok && (state != REQ);
   assign retire   = eret && (in_service != 3'b000);
   assign set_mask = (state == REQ && int_ack) ? (3'b001 << int_id) : 3'b000;
   assign in_service_next = (in_service | set_mask) & ~(retire ? retire_mask : 3'b000);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      int_req    = 1'b0;
      case (state)
         IDLE: begin
            if (qualify) state_next = REQ;
         end
         REQ: begin
            int_req = 1'b1;
            if (int_ack)  state_next = SERVICE;
            else if (!ie) state_next = (in_service_next != 3'b000) ? SERVICE : IDLE;
         end
         SERVICE: begin
            if (qualify)                           state_next = REQ;
            else if (in_service_next == 3'b000)    state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         int_id     <= 2'd0;
         int_vec    <= 32'd0;
         in_service <= 3'b000;
         Clr        <= 1'b0;
         ClrInt     <= 3'b000;
      end else begin
         in_service <= in_service_next;
         Clr        <= retire;
         ClrInt     <= retire ? retire_mask : 3'b000;
         if (qualify) begin
            int_id  <= cand_idx;
            int_vec <= VEC_BASE + VEC_STRIDE * {30'd0, cand_idx};
         end
      end
   end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt arbiter and service tracker on the consumer side of the 3-line pending-interrupt register in the CSR unit. Takes the pending vector, picks the highest-priority eligible source and requests a trap from the pipeline with a handler vector. It tracks in-service sources across handler entry and exit. On return from a handler it drives the one-cycle clear strobe and one-hot clear mask back to the pending register.

## Interface
- VEC_BASE, 32'h0000_1000, handler address for source 0
- VEC_STRIDE, 32'h0000_0100, address spacing between handlers
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- IR  in  3  pending interrupts from pending register; bit 2 highest priority, bit 0 lowest
- ie  in  1  global interrupt enable from CSR
- int_ack  in  1  pipeline has taken the trap for the current request
- eret  in  1  pipeline retires a handler-return instruction, one-cycle pulse
- int_req  out  1  trap request to pipeline
- int_id  out  2  id (0..2) of requested source
- int_vec  out  32  handler address, VEC_BASE + int_id*VEC_STRIDE, 32-bit wrap
- in_service  out  3  sources whose handler is active
- Clr  out  1  clear strobe to pending register, one cycle
- ClrInt  out  3  one-hot clear mask, valid with Clr, zero otherwise

## Operation
- Reset values: int_req=0, int_id=0, int_vec=0, in_service=0, Clr=0, ClrInt=0, state IDLE.
- Masking: eligible = IR & ~in_service & ~ClrInt_reg. Bits being cleared this cycle are masked, because IR still shows them until the next edge.
- Priority candidate: the highest set bit of eligible. It qualifies only if ie=1 and the preemption rule (Configuration) permits it.
- FSM:
  - IDLE: nothing in service, no request. A qualifying candidate moves to REQ.
  - REQ: int_req=1. int_id and int_vec are frozen and not re-arbitrated, even if a higher source arrives.
    - int_ack=1: set in_service[int_id], go to SERVICE.
    - ie=0 and int_ack=0: withdraw, drop int_req, return to IDLE or SERVICE according to in_service.
  - SERVICE: at least one source in service. A qualifying candidate moves to REQ. An eret that empties in_service moves to IDLE.
- eret handling:
  - Retire the highest set bit of in_service: clear that bit, then register Clr=1 and ClrInt=that bit for exactly one cycle.
  - eret with in_service=0 is ignored: no Clr, no state change.
- eret and int_ack in the same cycle: the retire mask is computed from in_service before the edge. The new bit is set and the old bit cleared on the same edge.
- Source drops from IR while in REQ: the request is still honoured on ack. A spurious trap is the handler's concern.

## Timing
- Candidate to int_req: 1 cycle. IR valid at edge N gives int_req high after edge N+1.
- int_req stays high until the edge on which int_ack=1 is sampled. int_req is low the following cycle. A new request can rise one cycle later at the earliest.
- int_id and int_vec change only on the edge that raises int_req.
- eret to Clr: 1 cycle. eret at edge N gives Clr/ClrInt high for the cycle after edge N, low after edge N+1.
- After a Clr cycle, the same source is re-requestable once IR reflects a new edge.
- rst mid-request or mid-service: all state cleared on the next edge. No Clr is issued for sources in service.

## Configuration
- INT_NEST_EN defined:
  - Preemption allowed. A candidate qualifies in SERVICE if its priority is strictly higher than the highest set bit of in_service.
  - in_service may hold up to 3 bits.
  - Returns retire in LIFO order (highest bit first).
- INT_NEST_EN undefined:
  - A candidate qualifies only when in_service=0, so in_service is at most one-hot.
  - int_req is never asserted while in SERVICE.

## Test plan
- Basic entry and exit: IR=3'b001, ie=1 → int_req=1, int_id=0, int_vec=32'h1000. After ack: in_service=001, no req. eret → Clr=1 and ClrInt=001 for one cycle, then IDLE.
- Priority: IR=3'b101 → int_id=2, int_vec=32'h1200. After that handler's eret, source 0 is requested. No re-request of 2 during the Clr cycle.
- Frozen request: IR=001 with req pending, then IR=101 before ack → int_id stays 0 until ack.
- Withdrawal: req high, ie→0 without ack → int_req=0 next cycle, in_service unchanged.
- Nesting with INT_NEST_EN: serving 0, IR gains bit 1 → req id 1. Ack → in_service=011. Two erets give ClrInt=010, then 001.
- Nesting without INT_NEST_EN: same stimulus → no req until eret.
- Reset mid-service: in_service=011, then rst → all outputs 0 next cycle, Clr stays 0.
